// File: rtl/dog_sprite_sequencer.sv
// Dog sprite pixel pipeline and walk-cycle frame sequencer.
// Optional horizontal mirroring is enabled with SPRITE_MIRROR_EN.
module dog_sprite_sequencer #(
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 64,
  parameter int FRAMES = 4,
  parameter int FRAME_HOLD = 8,
  localparam int XW = $clog2(SPRITE_W),
  localparam int YW = $clog2(SPRITE_H),
  localparam int AW = XW + YW
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_start,
  input  logic          run,
  input  logic          pix_valid,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic [9:0]    SpriteX,
  input  logic [9:0]    SpriteY,
`ifdef SPRITE_MIRROR_EN
  input  logic          mirror_x,
`endif
  output logic [AW-1:0] rom_addr,
  output logic [1:0]    rom_sel,
  input  logic [3:0]    rom_data,
  output logic [3:0]    pal_index,
  input  logic [11:0]   pal_rgb,
  output logic [11:0]   sprite_rgb,
  output logic          sprite_on,
  output logic          out_valid
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t      state;
  logic [7:0]  hold;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [10:0] dx;
  logic [10:0] dy;
  logic [XW-1:0] col;
  logic        hit;
  logic        hit0;
  logic        hit1;
  logic        v0;
  logic        v1;
  logic        last_hold;
  logic        last_frame;
  logic        stepping;
  logic [1:0]  next_sel;

  // 11-bit differences: pixels left of/above the sprite go negative
  assign dx = {1'b0, DrawX} - {1'b0, pos_x};
  assign dy = {1'b0, DrawY} - {1'b0, pos_y};
  assign hit = pix_valid && (dx < 11'(SPRITE_W))
               && (dy < 11'(SPRITE_H));

`ifdef SPRITE_MIRROR_EN
  logic mirror;
  assign col = mirror ? ~dx[XW-1:0] : dx[XW-1:0];
`else
  assign col = dx[XW-1:0];
`endif

  assign last_hold = hold == 8'(FRAME_HOLD - 1);
  assign last_frame = rom_sel == 2'(FRAMES - 1);
  assign next_sel = !last_hold ? rom_sel
                  : last_frame ? 2'd0
                  : rom_sel + 2'd1;
  // the pulse that leaves IDLE already counts toward the hold
  assign stepping = (state != IDLE) || run;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      hold       <= '0;
      rom_sel    <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
`ifdef SPRITE_MIRROR_EN
      mirror     <= 1'b0;
`endif
      v0         <= 1'b0;
      hit0       <= 1'b0;
      rom_addr   <= '0;
      v1         <= 1'b0;
      hit1       <= 1'b0;
      pal_index  <= '0;
      out_valid  <= 1'b0;
      sprite_on  <= 1'b0;
      sprite_rgb <= '0;
    end else begin
      if (frame_start) begin
        pos_x <= SpriteX;
        pos_y <= SpriteY;
`ifdef SPRITE_MIRROR_EN
        mirror <= mirror_x;
`endif
        if (stepping) begin
          hold    <= last_hold ? 8'd0 : hold + 8'd1;
          rom_sel <= next_sel;
          if (run)
            state <= RUN;
          else if (last_hold && last_frame)
            state <= IDLE;
          else
            state <= STOPPING;
        end
      end
      v0         <= pix_valid;
      hit0       <= hit;
      rom_addr   <= hit ? {dy[YW-1:0], col} : '0;
      v1         <= v0;
      hit1       <= hit0;
      pal_index  <= hit0 ? rom_data : 4'd0;
      out_valid  <= v1;
      sprite_on  <= hit1 && (pal_index != 4'd0);
      sprite_rgb <= pal_rgb;
    end
  end

endmodule

// File: tb/tb_dog_sprite_sequencer.sv
// Scoreboard bench for dog_sprite_sequencer with a behavioural model.
// Builds with or without SPRITE_MIRROR_EN.
module tb_dog_sprite_sequencer;
  localparam int SW = 64;
  localparam int SH = 64;
  localparam int FR = 4;
  localparam int FH = 8;
  localparam int AW = $clog2(SW * SH);
`ifdef SPRITE_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic run = 1'b0;
  logic pix_valid = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [9:0] SpriteX = '0;
  logic [9:0] SpriteY = '0;
`ifdef SPRITE_MIRROR_EN
  logic mirror_x = 1'b0;
`endif
  logic [AW-1:0] rom_addr;
  logic [1:0] rom_sel;
  logic [3:0] rom_data;
  logic [3:0] pal_index;
  logic [11:0] pal_rgb;
  logic [11:0] sprite_rgb;
  logic sprite_on;
  logic out_valid;

  logic [3:0] rom_mem [SW*SH];
  logic [11:0] pal_mem [16];

  assign rom_data = rom_mem[rom_addr];
  assign pal_rgb = pal_mem[pal_index];

  dog_sprite_sequencer #(
    .SPRITE_W(SW), .SPRITE_H(SH),
    .FRAMES(FR), .FRAME_HOLD(FH)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_start(frame_start),
    .run(run),
    .pix_valid(pix_valid),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .SpriteX(SpriteX),
    .SpriteY(SpriteY),
`ifdef SPRITE_MIRROR_EN
    .mirror_x(mirror_x),
`endif
    .rom_addr(rom_addr),
    .rom_sel(rom_sel),
    .rom_data(rom_data),
    .pal_index(pal_index),
    .pal_rgb(pal_rgb),
    .sprite_rgb(sprite_rgb),
    .sprite_on(sprite_on),
    .out_valid(out_valid)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct { int cyc; int addr; int sel; } a_t;
  typedef struct { int cyc; int rgb; int on; } o_t;
  a_t aq[$];
  o_t oq[$];

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int m_px, m_py, m_cnt, m_sel;
  bit m_act, m_mir;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  task automatic model_reset();
    m_px = 0; m_py = 0; m_cnt = 0; m_sel = 0;
    m_act = 1'b0; m_mir = 1'b0;
    aq.delete();
    oq.delete();
  endtask

  // one frame_start pulse of the walk cycle
  task automatic anim(input bit r);
    bit wr;
    if (!m_act && !r) return;
    wr = 1'b0;
    m_cnt++;
    if (m_cnt == FH) begin
      m_cnt = 0;
      m_sel = (m_sel + 1) % FR;
      wr = (m_sel == 0);
    end
    m_act = r || !wr;
  endtask

  task automatic step(input bit fs, input bit pv, input int x, input int y,
                      input int sx, input int sy, input bit r, input bit mx);
    int dx, dy, addr, idx;
    bit h;
    a_t a;
    o_t o;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    frame_start = fs;
    pix_valid = pv;
    DrawX = 10'(x);
    DrawY = 10'(y);
    SpriteX = 10'(sx);
    SpriteY = 10'(sy);
    run = r;
`ifdef SPRITE_MIRROR_EN
    mirror_x = mx;
`endif
    dx = x - m_px;
    dy = y - m_py;
    h = pv && dx >= 0 && dx < SW && dy >= 0 && dy < SH;
    addr = h ? dy * SW + (m_mir ? SW - 1 - dx : dx) : 0;
    idx = h ? int'(rom_mem[addr]) : 0;
    if (fs) begin
      m_px = sx;
      m_py = sy;
      m_mir = mx;
      anim(r);
    end
    a.cyc = cyc; a.addr = addr; a.sel = m_sel;
    aq.push_back(a);
    if (pv) begin
      o.cyc = cyc; o.rgb = int'(pal_mem[idx]); o.on = int'(idx != 0);
      oq.push_back(o);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, m_px, m_py, run, m_mir);
  endtask

  task automatic pulse(input bit r);
    step(1'b1, 1'b0, 0, 0, m_px, m_py, r, m_mir);
    step(1'b0, 1'b0, 0, 0, m_px, m_py, r, m_mir);
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    pix_valid = 1'b1;
    frame_start = 1'b0;
    DrawX = 10'd3;
    DrawY = 10'd3;
    repeat (2) begin
      @(posedge Clk);
      #1;
      model_reset();
      @(negedge Clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_sprite_on", int'(sprite_on), 0);
      chk("rst_sprite_rgb", int'(sprite_rgb), 0);
      chk("rst_rom_sel", int'(rom_sel), 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
    end
  endtask

  task automatic probe(input string nm, input int x, input int y,
                       input int ea, input int ei, input int eo);
    step(1'b0, 1'b1, x, y, m_px, m_py, 1'b0, m_mir);
    idle();
    @(negedge Clk);
    chk({nm, "_addr"}, int'(rom_addr), ea);
    idle();
    @(negedge Clk);
    chk({nm, "_idx"}, int'(pal_index), ei);
    idle();
    @(negedge Clk);
    chk({nm, "_on"}, int'(sprite_on), eo);
    chk({nm, "_rgb"}, int'(sprite_rgb), int'(pal_mem[ei]));
  endtask

  task automatic latch(input int sx, input int sy, input bit mx);
    step(1'b1, 1'b0, 0, 0, sx, sy, 1'b0, mx);
  endtask

  // scoreboard monitor
  always @(negedge Clk) begin : mon
    a_t a;
    o_t o;
    if (Reset_n) begin
      if (aq.size() > 0 && aq[0].cyc == cyc - 1) begin
        a = aq.pop_front();
        chk("sb_rom_addr", int'(rom_addr), a.addr);
        chk("sb_rom_sel", int'(rom_sel), a.sel);
      end
      if (out_valid) begin
        if (oq.size() == 0) begin
          chk("sb_spurious_valid", int'(out_valid), 0);
        end else begin
          o = oq.pop_front();
          chk("sb_latency", cyc - o.cyc, 3);
          chk("sb_sprite_rgb", int'(sprite_rgb), o.rgb);
          chk("sb_sprite_on", int'(sprite_on), o.on);
        end
      end else if (oq.size() > 0 && cyc - oq[0].cyc >= 3) begin
        o = oq.pop_front();
        chk("sb_missing_valid", int'(out_valid), 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit r;
    bit fs;
    bit pv;
    bit mx;
    int x, y;
    for (int i = 0; i < SW * SH; i++) rom_mem[i] = 4'($urandom);
    for (int i = 0; i < 16; i++) pal_mem[i] = 12'($urandom);
    rom_mem[133] = 4'd3;
    rom_mem[134] = 4'd0;
    pal_mem[3] = 12'h940;
    model_reset();

    do_reset();

    latch(100, 50, 1'b0);
    probe("hit", 105, 52, 133, 3, 1);
    probe("transp", 106, 52, 134, 0, 0);
    probe("dx64", 164, 52, 0, 0, 0);
    probe("last_col", 163, 52, 191, int'(rom_mem[191]),
          int'(rom_mem[191] != 0));
    probe("above", 105, 49, 0, 0, 0);
    probe("below", 105, 114, 0, 0, 0);

    latch(620, 50, 1'b0);
    probe("clip", 639, 52, 147, int'(rom_mem[147]),
          int'(rom_mem[147] != 0));

    latch(1000, 0, 1'b0);
    probe("neg_dx", 5, 10, 0, 0, 0);

    // position latch: mid-frame change is ignored until frame_start
    latch(100, 50, 1'b0);
    step(1'b0, 1'b1, 105, 52, 300, 60, 1'b0, 1'b0);
    idle();
    @(negedge Clk);
    chk("latch_hold", int'(rom_addr), 133);
    step(1'b1, 1'b1, 105, 52, 300, 60, 1'b0, 1'b0);
    idle();
    @(negedge Clk);
    chk("fs_coincident", int'(rom_addr), 133);
    probe("new_pos", 305, 62, 133, 3, 1);

`ifdef SPRITE_MIRROR_EN
    latch(100, 50, 1'b1);
    probe("mirror", 105, 50, 58, int'(rom_mem[58]),
          int'(rom_mem[58] != 0));
    latch(100, 50, 1'b0);
`else
    latch(100, 50, 1'b0);
    probe("nomirror", 105, 50, 5, int'(rom_mem[5]),
          int'(rom_mem[5] != 0));
`endif

    // walk-cycle animation
    do_reset();
    repeat (8) pulse(1'b1);
    @(negedge Clk);
    chk("sel_after8", int'(rom_sel), 1);
    repeat (16) pulse(1'b1);
    @(negedge Clk);
    chk("sel_after24", int'(rom_sel), 3);
    repeat (24) pulse(1'b1);
    @(negedge Clk);
    chk("sel_before_stop", int'(rom_sel), 2);
    repeat (8) pulse(1'b0);
    @(negedge Clk);
    chk("stop_step3", int'(rom_sel), 3);
    repeat (8) pulse(1'b0);
    @(negedge Clk);
    chk("stop_wrap", int'(rom_sel), 0);
    repeat (8) pulse(1'b0);
    @(negedge Clk);
    chk("idle_hold", int'(rom_sel), 0);

    // randomized traffic with a reset in the middle
    r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        do_reset();
        r = 1'b0;
      end
      fs = ($urandom_range(0, 29) == 0);
      pv = ($urandom_range(0, 3) != 0);
      x = clampc(m_px + int'($urandom_range(0, 80)) - 8);
      y = clampc(m_py + int'($urandom_range(0, 80)) - 8);
      if ($urandom_range(0, 7) == 0) x = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) y = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 199) == 0) r = ~r;
      mx = MIR & 1'($urandom);
      step(fs, pv, x, y, int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 1023)), r, mx);
    end
    repeat (6) idle();
    @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dog_sprite_sequencer.md
# dog_sprite_sequencer

Per-pixel controller that sequences the dog sprite datapath: it decides whether the current VGA pixel falls inside the dog sprite, addresses the active animation-frame ROM, drives the 4-bit palette index, and returns a registered 12-bit colour with a transparency flag. It also runs the walk-cycle animation, advancing the ROM frame select on vertical-blank pulses. It sits between the VGA timing block, the per-frame sprite ROMs and the 16-entry palette, and feeds the colour mapper.

## Interface
Parameters:
- SPRITE_W, 64: sprite width in pixels (power of 2).
- SPRITE_H, 64: sprite height in pixels (power of 2).
- FRAMES, 4: animation frames (ROMs), 2..4.
- FRAME_HOLD, 8: frame_start pulses per animation frame, 1..255.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- run  in  1  animation enable (level).
- pix_valid  in  1  DrawX/DrawY are an active pixel this cycle.
- DrawX, DrawY  in  10  current pixel coordinate.
- SpriteX, SpriteY  in  10  sprite top-left; sampled only on frame_start.
- rom_addr  out  log2(W*H)  row-major address dy*SPRITE_W+dx.
- rom_sel  out  2  animation frame index, 0..FRAMES-1.
- rom_data  in  4  ROM output, valid one cycle after rom_addr.
- pal_index  out  4  palette index (combinational palette lookup).
- pal_rgb  in  12  palette output {R,G,B} for pal_index.
- sprite_rgb  out  12  registered colour.
- sprite_on  out  1  pixel is inside sprite and non-transparent.
- out_valid  out  1  sprite_rgb/sprite_on correspond to a pixel.

## Operation
- Position latch: on frame_start, posX/posY <= SpriteX/SpriteY. A pixel in the same cycle uses the old latched value.
- Stage 0 (registered): dx = DrawX-posX, dy = DrawY-posY in 11-bit two's complement; hit = pix_valid & 0<=dx<SPRITE_W & 0<=dy<SPRITE_H. On hit, drive rom_addr; otherwise hold rom_addr at 0. Register hit and pix_valid.
- Stage 1: register rom_data into pal_index, forced to 0 when hit=0.
- Stage 2: sprite_rgb <= pal_rgb; sprite_on <= hit & (pal_index != 0); out_valid <= delayed pix_valid.
- Transparency: index 0 only is transparent. Indices 5-15 are opaque even though they carry background colour.
- Clipping: a sprite partially off-screen is clipped naturally. Positions wrap nowhere, and dx/dy are never truncated to 10 bits.
- Animation FSM (updates only on frame_start):
  - IDLE: rom_sel=0, hold counter 0. Goes to RUN when run=1 on frame_start.
  - RUN: counter increments. At FRAME_HOLD-1, counter clears and rom_sel <= (rom_sel+1) mod FRAMES. Goes to STOPPING if run=0.
  - STOPPING: keeps stepping like RUN until rom_sel wraps to 0, then goes to IDLE. If run=1 is seen again, returns to RUN with no frame skip.
- rom_sel changes only on frame_start cycles, never mid-frame.

## Timing
- Latency pix_valid -> out_valid is 3 cycles, fully pipelined, one pixel per cycle, no stalls.
- rom_addr is registered and leads pal_index by 1 cycle. pal_rgb is sampled in the same cycle pal_index is valid.
- Reset values (Reset_n=0 at a Clk edge):
  - state IDLE, rom_sel 0, hold counter 0.
  - posX/posY 0, rom_addr 0, pal_index 0.
  - sprite_rgb 12'h000, sprite_on 0, out_valid 0.
- Reset mid-line: all pipeline valids clear on the same edge. The first valid output after reset release appears 3 cycles after the first pix_valid.
- Simultaneous frame_start and pix_valid: pixel processed with the pre-update position and frame. The FSM and position update on that edge.

## Configuration
- SPRITE_MIRROR_EN defined:
  - adds input mirror_x (1 bit), sampled on frame_start.
  - when the latched value is 1, column = SPRITE_W-1-dx for address generation; hit test unchanged.
- Undefined: no mirror_x port, and addressing is as described above.

## Test plan
- Reset: hold Reset_n=0 for 2 cycles with pix_valid=1 -> out_valid=0, sprite_on=0, sprite_rgb=000, rom_sel=0 throughout. First out_valid comes exactly 3 cycles after the first post-reset pix_valid.
- Hit/address: SpriteX=100, SpriteY=50 latched; DrawX=105, DrawY=52 -> rom_addr=2*64+5=133 next cycle. If rom_data=3, then pal_index=3 and, with pal_rgb=940, 2 cycles later sprite_rgb=940 and sprite_on=1.
- Transparency and bounds:
  - rom_data=0 inside the sprite -> sprite_on=0.
  - DrawX=164 (dx=64) -> sprite_on=0 and pal_index=0.
  - SpriteX=620, DrawX=639 -> hit, dx=19.
- Animation: run=1, FRAME_HOLD=8, FRAMES=4 -> rom_sel steps 0->1 after 8 frame_start pulses and reaches 3 after 24. Dropping run at rom_sel=2 -> steps to 3, wraps to 0, then IDLE.
- Position latch: change SpriteX mid-frame -> addresses unchanged until the next frame_start. frame_start coincident with pix_valid -> that pixel uses the old position.
- SPRITE_MIRROR_EN: mirror_x=1, dx=5, dy=0 -> rom_addr=58. Without the macro the same pixel gives rom_addr=5.
